// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM stage with D-cache req/gnt/rvalid handshake, store
// lane alignment, load extraction/extension and misalign trap.  Rev 1.0
// ============================================================================
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 exmem_valid_i,
  input  logic [XLEN-1:0]      exmem_op_c_i,
  input  logic [RADDR_W-1:0]   exmem_reg_waddr_i,
  input  logic                 exmem_reg_we_i,
  input  logic                 exmem_mtype_i,
  input  logic                 exmem_mem_rw_i,
  input  logic [1:0]           exmem_mem_width_i,
  input  logic                 exmem_mem_rdtype_i,
  input  logic [ADDR_W-1:0]    exmem_mem_addr_i,
  input  logic [XLEN-1:0]      exmem_mem_wr_data_i,
  output logic                 stall_o,
  output logic                 dc_req_o,
  output logic                 dc_we_o,
  output logic [ADDR_W-1:0]    dc_addr_o,
  output logic [XLEN/8-1:0]    dc_wstrb_o,
  output logic [XLEN-1:0]      dc_wdata_o,
  input  logic                 dc_gnt_i,
  input  logic                 dc_rvalid_i,
  input  logic [XLEN-1:0]      dc_rdata_i,
  output logic                 memwb_valid_o,
  output logic [XLEN-1:0]      memwb_data_o,
  output logic [RADDR_W-1:0]   memwb_reg_waddr_o,
  output logic                 memwb_reg_we_o,
  output logic                 memwb_misalign_o
);
  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                w_aligned;
  logic                w_mem_op;
  logic                w_accept;
  logic                w_misalign;
  logic                w_plain;
  logic [LANE_W-1:0]   w_lane;
  logic [BYTES-1:0]    w_strb_base;
  logic [XLEN-1:0]     w_shifted;
  logic [XLEN-1:0]     w_mask;
  logic                w_sign;
  logic [XLEN-1:0]     w_load_data;

  logic [LANE_W-1:0]   r_lane;
  logic [1:0]          r_width;
  logic                r_rdtype;
  logic [RADDR_W-1:0]  r_waddr;
  logic                r_reg_we;

  assign w_lane     = exmem_mem_addr_i[LANE_W-1:0];
  assign w_mem_op   = exmem_valid_i & exmem_mtype_i;
  assign w_accept   = w_mem_op & w_aligned;
  assign w_misalign = w_mem_op & ~w_aligned;
  assign w_plain    = exmem_valid_i & ~exmem_mtype_i;

  always_comb begin
    w_aligned = 1'b0;
    case (exmem_mem_width_i)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~exmem_mem_addr_i[0];
      2'b10:   w_aligned = (exmem_mem_addr_i[1:0] == 2'b00);
      default: w_aligned = (XLEN == 64) && (exmem_mem_addr_i[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    w_strb_base = '1;
    case (exmem_mem_width_i)
      2'b00:   w_strb_base = BYTES'(1);
      2'b01:   w_strb_base = BYTES'(3);
      2'b10:   w_strb_base = BYTES'(15);
      default: w_strb_base = '1;
    endcase
  end

  // Load path works from the fields latched at accept; the bus is not stable then.
  assign w_shifted = dc_rdata_i >> {r_lane, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (r_width)
      2'b00: begin
        w_mask = XLEN'(8'hFF);
        w_sign = w_shifted[7];
      end
      2'b01: begin
        w_mask = XLEN'(16'hFFFF);
        w_sign = w_shifted[15];
      end
      2'b10: begin
        w_mask = XLEN'(32'hFFFF_FFFF);
        w_sign = w_shifted[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
    w_load_data = (w_shifted & w_mask) | ({XLEN{w_sign & ~r_rdtype}} & ~w_mask);
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_REQ;
          stall_o     = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = ~(dc_we_o & dc_gnt_i);
        if (dc_gnt_i) w_state_nxt = dc_we_o ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        stall_o = ~dc_rvalid_i;
        if (dc_rvalid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst_n) stall_o = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_req_o          <= 1'b0;
      dc_we_o           <= 1'b0;
      dc_addr_o         <= '0;
      dc_wstrb_o        <= '0;
      dc_wdata_o        <= '0;
      memwb_valid_o     <= 1'b0;
      memwb_data_o      <= '0;
      memwb_reg_waddr_o <= '0;
      memwb_reg_we_o    <= 1'b0;
      memwb_misalign_o  <= 1'b0;
      r_lane            <= '0;
      r_width           <= 2'b00;
      r_rdtype          <= 1'b0;
      r_waddr           <= '0;
      r_reg_we          <= 1'b0;
    end else begin
      memwb_valid_o    <= 1'b0;
      memwb_reg_we_o   <= 1'b0;
      memwb_misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            dc_req_o   <= 1'b1;
            dc_we_o    <= exmem_mem_rw_i;
            dc_addr_o  <= {exmem_mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            dc_wstrb_o <= exmem_mem_rw_i ? (w_strb_base << w_lane) : '0;
            dc_wdata_o <= exmem_mem_rw_i ? (exmem_mem_wr_data_i << {w_lane, 3'b000}) : '0;
            r_lane     <= w_lane;
            r_width    <= exmem_mem_width_i;
            r_rdtype   <= exmem_mem_rdtype_i;
            r_waddr    <= exmem_reg_waddr_i;
            r_reg_we   <= exmem_reg_we_i;
          end else if (w_misalign) begin
            memwb_valid_o     <= 1'b1;
            memwb_misalign_o  <= 1'b1;
            memwb_data_o      <= '0;
            memwb_reg_waddr_o <= exmem_reg_waddr_i;
          end else if (w_plain) begin
            memwb_valid_o     <= 1'b1;
            memwb_data_o      <= exmem_op_c_i;
            memwb_reg_waddr_o <= exmem_reg_waddr_i;
            memwb_reg_we_o    <= exmem_reg_we_i;
          end
        end
        S_REQ: begin
          if (dc_gnt_i) begin
            dc_req_o <= 1'b0;
            if (dc_we_o) begin
              memwb_valid_o     <= 1'b1;
              memwb_reg_waddr_o <= r_waddr;
            end
          end
        end
        S_RESP: begin
          if (dc_rvalid_i) begin
            memwb_valid_o     <= 1'b1;
            memwb_data_o      <= w_load_data;
            memwb_reg_waddr_o <= r_waddr;
            memwb_reg_we_o    <= r_reg_we;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit: directed + randomized checks of 32- and 64-bit instances
// against a behavioural model of the memory-stage rules.
module tb_mem_access_unit;
  logic        clk, rst_n;
  logic        valid32, valid64, mtype, rw, rdtype, we, gnt, rvalid;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [63:0] wr_data, op_c, rdata;
  logic [4:0]  waddr;

  logic        s32, req32, dwe32, mv32, mwe32, mis32;
  logic [31:0] daddr32, wdata32, md32;
  logic [3:0]  strb32;
  logic [4:0]  mwa32;
  logic        s64, req64, dwe64, mv64, mwe64, mis64;
  logic [31:0] daddr64;
  logic [63:0] wdata64, md64;
  logic [7:0]  strb64;
  logic [4:0]  mwa64;

  bit          sel;
  logic        o_stall, o_req, o_dwe, o_mv, o_mwe, o_mis;
  logic [31:0] o_daddr;
  logic [7:0]  o_strb;
  logic [63:0] o_wdata, o_md;
  logic [4:0]  o_mwa;
  logic [63:0] last_data;
  int          tests = 0;
  int          failed = 0;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .RADDR_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .exmem_valid_i(valid32), .exmem_op_c_i(op_c[31:0]), .exmem_reg_waddr_i(waddr),
    .exmem_reg_we_i(we), .exmem_mtype_i(mtype), .exmem_mem_rw_i(rw),
    .exmem_mem_width_i(width), .exmem_mem_rdtype_i(rdtype), .exmem_mem_addr_i(addr),
    .exmem_mem_wr_data_i(wr_data[31:0]), .stall_o(s32), .dc_req_o(req32), .dc_we_o(dwe32),
    .dc_addr_o(daddr32), .dc_wstrb_o(strb32), .dc_wdata_o(wdata32), .dc_gnt_i(gnt),
    .dc_rvalid_i(rvalid), .dc_rdata_i(rdata[31:0]), .memwb_valid_o(mv32), .memwb_data_o(md32),
    .memwb_reg_waddr_o(mwa32), .memwb_reg_we_o(mwe32), .memwb_misalign_o(mis32));

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .RADDR_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .exmem_valid_i(valid64), .exmem_op_c_i(op_c), .exmem_reg_waddr_i(waddr),
    .exmem_reg_we_i(we), .exmem_mtype_i(mtype), .exmem_mem_rw_i(rw),
    .exmem_mem_width_i(width), .exmem_mem_rdtype_i(rdtype), .exmem_mem_addr_i(addr),
    .exmem_mem_wr_data_i(wr_data), .stall_o(s64), .dc_req_o(req64), .dc_we_o(dwe64),
    .dc_addr_o(daddr64), .dc_wstrb_o(strb64), .dc_wdata_o(wdata64), .dc_gnt_i(gnt),
    .dc_rvalid_i(rvalid), .dc_rdata_i(rdata), .memwb_valid_o(mv64), .memwb_data_o(md64),
    .memwb_reg_waddr_o(mwa64), .memwb_reg_we_o(mwe64), .memwb_misalign_o(mis64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_stall = sel ? s64   : s32;
    o_req   = sel ? req64 : req32;
    o_dwe   = sel ? dwe64 : dwe32;
    o_daddr = sel ? daddr64 : daddr32;
    o_strb  = sel ? strb64 : {4'b0, strb32};
    o_wdata = sel ? wdata64 : {32'b0, wdata32};
    o_mv    = sel ? mv64  : mv32;
    o_md    = sel ? md64  : {32'b0, md32};
    o_mwa   = sel ? mwa64 : mwa32;
    o_mwe   = sel ? mwe64 : mwe32;
    o_mis   = sel ? mis64 : mis32;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] trunc(input bit x, input logic [63:0] v);
    return x ? v : (v & 64'hFFFF_FFFF);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, o_stall, 0);
    chk({tag, "_req"},   o_req, 0);
    chk({tag, "_dwe"},   o_dwe, 0);
    chk({tag, "_daddr"}, o_daddr, 0);
    chk({tag, "_strb"},  o_strb, 0);
    chk({tag, "_wdata"}, o_wdata, 0);
    chk({tag, "_mv"},    o_mv, 0);
    chk({tag, "_md"},    o_md, 0);
    chk({tag, "_mwa"},   o_mwa, 0);
    chk({tag, "_mwe"},   o_mwe, 0);
    chk({tag, "_mis"},   o_mis, 0);
  endtask

  // Called at a falling edge; drives one EX/MEM op, plays the D-cache and
  // returns at the falling edge where the op's memwb result is checked.
  task automatic run_op(input bit x, input bit mt, input bit st, input logic [1:0] w,
                        input bit zx, input logic [31:0] a, input logic [63:0] wd,
                        input logic [63:0] opc, input logic [4:0] wa, input bit rwe,
                        input int gd, input int rd, input logic [63:0] rdat);
    int xl, nb, lane;
    bit mis, acc, exp_we;
    logic [63:0] mask, e;
    xl   = x ? 64 : 32;
    nb   = 1 << w;
    lane = a % (xl / 8);
    mis  = mt && (((a % nb) != 0) || (w == 2'b11 && xl == 32));
    acc  = mt && !mis;
    sel = x;
    valid32 = !x; valid64 = x; mtype = mt; rw = st; width = w; rdtype = zx;
    addr = a; wr_data = wd; op_c = opc; waddr = wa; we = rwe; gnt = 0; rvalid = 0;
    #1;
    chk("accept_stall", o_stall, acc);
    chk("accept_noreq", o_req, 0);
    if (acc) begin
      for (int d = 0; d <= gd; d++) begin
        @(negedge clk);
        gnt = (d == gd);
        rvalid = (d != gd) && ($urandom_range(0, 1) == 1);
        rdata = {$urandom, $urandom};
        #1;
        chk("req_req", o_req, 1);
        chk("req_we", o_dwe, st);
        chk("req_addr", o_daddr, a - lane);
        if (st) begin
          chk("req_strb", o_strb, ((64'd1 << nb) - 1) << lane);
          chk("req_wdata", o_wdata, trunc(x, wd << (8 * lane)));
        end
        chk("req_stall", o_stall, !(st && gnt));
        chk("req_mv", o_mv, 0);
      end
      if (!st) begin
        for (int d = 0; d <= rd; d++) begin
          @(negedge clk);
          gnt = 0;
          rvalid = (d == rd);
          rdata = (d == rd) ? rdat : {$urandom, $urandom};
          #1;
          chk("resp_req", o_req, 0);
          chk("resp_stall", o_stall, !rvalid);
          chk("resp_mv", o_mv, 0);
        end
      end
    end
    @(negedge clk);
    valid32 = 0; valid64 = 0; gnt = 0; rvalid = 0;
    exp_we = !mt ? rwe : (acc && !st && rwe);
    chk("ret_valid", o_mv, 1);
    chk("ret_misalign", o_mis, mis);
    chk("ret_we", o_mwe, exp_we);
    chk("ret_noreq", o_req, 0);
    if (exp_we) chk("ret_waddr", o_mwa, wa);
    if (!mt) chk("ret_opc", o_md, trunc(x, opc));
    if (acc && !st) begin
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 1);
      e = (trunc(x, rdat) >> (8 * lane)) & mask;
      if (!zx && nb < 8 && e[8 * nb - 1]) e = e | ~mask;
      chk("ret_load", o_md, trunc(x, e));
    end
    last_data = o_md;
  endtask

  task automatic bubble();
    @(negedge clk);
    chk("bubble_mv", o_mv, 0);
  endtask

  initial begin
    sel = 0; rst_n = 0;
    valid32 = 1; valid64 = 1; mtype = 1; rw = 0; width = 2'b10; rdtype = 0;
    addr = 32'h100; wr_data = 0; op_c = 0; waddr = 0; we = 1; gnt = 0; rvalid = 0; rdata = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst32");
    sel = 1; #1;
    chk_all_zero("rst64");
    valid32 = 0; valid64 = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // directed
    run_op(0, 0, 0, 2'b00, 0, 32'h0, 64'h0, 64'hDEAD_BEEF, 5'd5, 1, 0, 0, 64'h0);
    chk("nonmem_lit", last_data, 64'hDEAD_BEEF);
    run_op(0, 1, 0, 2'b00, 0, 32'h1003, 64'h0, 64'h0, 5'd7, 1, 0, 2, 64'h8011_2233);
    chk("lb_lit", last_data, 64'hFFFF_FF80);
    run_op(0, 1, 0, 2'b00, 1, 32'h1003, 64'h0, 64'h0, 5'd7, 1, 1, 0, 64'h8011_2233);
    chk("lbu_lit", last_data, 64'h0000_0080);
    run_op(0, 1, 1, 2'b01, 0, 32'h2002, 64'h0000_ABCD, 64'h0, 5'd3, 1, 3, 0, 64'h0);
    run_op(0, 1, 0, 2'b10, 0, 32'h3001, 64'h0, 64'h0, 5'd9, 1, 0, 0, 64'h0);
    run_op(1, 1, 0, 2'b11, 0, 32'h8, 64'h0, 64'h0, 5'd4, 1, 0, 0, 64'h0123_4567_89AB_CDEF);
    chk("ld_lit", last_data, 64'h0123_4567_89AB_CDEF);
    run_op(1, 1, 0, 2'b01, 0, 32'h6, 64'h0, 64'h0, 5'd4, 1, 0, 0, 64'h8000_0000_0000_0000);
    chk("lh64_lit", last_data, 64'hFFFF_FFFF_FFFF_8000);
    run_op(0, 1, 1, 2'b11, 0, 32'h10, 64'h1, 64'h0, 5'd1, 1, 0, 0, 64'h0);
    bubble();

    // reset while a load sits in RESP
    sel = 0; valid32 = 1; mtype = 1; rw = 0; width = 2'b10; rdtype = 0;
    addr = 32'h40; we = 1; waddr = 5'd2;
    @(negedge clk); gnt = 1;
    @(negedge clk); gnt = 0;
    rst_n = 0; #1;
    chk_all_zero("rst_resp");
    valid32 = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); rvalid = 1; rdata = 64'h1234_5678; #1;
    chk("post_rst_stall", o_stall, 0);
    @(negedge clk); rvalid = 0;
    chk("post_rst_mv", o_mv, 0);
    chk("post_rst_req", o_req, 0);
    run_op(0, 1, 0, 2'b10, 0, 32'h44, 64'h0, 64'h0, 5'd2, 1, 0, 0, 64'hCAFE_F00D);
    chk("post_rst_load", last_data, 64'hCAFE_F00D);

    // randomized
    for (int x = 0; x < 2; x++) begin
      for (int i = 0; i < 80; i++) begin
        logic [31:0] ra;
        ra = $urandom;
        if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
        run_op(x[0], $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, ra,
               {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
               {$urandom, $urandom});
        repeat ($urandom_range(0, 2)) bubble();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
